a_rst_seq: RTL
==============

# a_rst_seq

Staged reset sequencer for the verification acceleration system. It sits directly downstream of the power-on reset pulse generator and consumes its active-low `init_rst_n` request. It drives one active-low reset per functional stage (clock/ctrl, NoC, emulation cores, host link), releasing them in fixed index order. Each stage must acknowledge readiness before the next is released, and the sequencer raises `sys_ready_o` once all stages are up.

## Interface

Parameters:
- `N_STAGES`, 4: number of sequenced reset outputs (1..16).
- `HOLD_CYCLES`, 16: cycles all stages are held in reset before stage 0 is released (≥1).
- `GAP_CYCLES`, 4: idle cycles between one stage's ready and the next stage's release (≥0).
- `TIMEOUT_CYCLES`, 1024: ready-wait limit per stage (timeout build only, ≥1).
- `CNT_W`, 16: internal counter width. Must hold the largest of the three counts.

Ports:
- `clk_ref`, input, 1: single clock. All logic is rising-edge.
- `rst_n_i`, input, 1: asynchronous active-low reset. Assertion acts immediately. Release is sampled on `clk_ref`.
- `init_rst_n_i`, input, 1: active-low reset request from the power-on pulse generator. Synchronous to `clk_ref`.
- `stage_rdy_i`, input, N_STAGES: per-stage ready acknowledge. Level-sensitive.
- `stage_rst_n_o`, output, N_STAGES: per-stage active-low reset. Registered.
- `sys_ready_o`, output, 1: all stages released and acknowledged. Registered.
- `fault_o`, output, 1: ready timeout occurred. Registered.
- `fault_stage_o`, output, max(1,clog2(N_STAGES)): index of the stage that timed out.

## Operation

- **States:** ASSERT, RELEASE, GAP, DONE, FAULT. FAULT exists in the timeout build only.
- **Async reset (`rst_n_i`=0):** state=ASSERT, all counters=0, `stage_rst_n_o`=0, `sys_ready_o`=0, `fault_o`=0, `fault_stage_o`=0.
- **Reset request (`init_rst_n_i`=0, sampled in any state):**
  - Next state is ASSERT. Counters clear. All `stage_rst_n_o`, `sys_ready_o` and `fault_o` go to 0 on the same edge.
  - The block stays in ASSERT while the request is held.
- **ASSERT:** the hold counter increments each edge with `init_rst_n_i`=1. On the edge where it reaches HOLD_CYCLES:
  - stage index k=0;
  - `stage_rst_n_o[0]` is set to 1;
  - state becomes RELEASE.
- **RELEASE (waiting on stage k):**
  - `stage_rdy_i[k]` is sampled each edge.
  - If it is high and k<N_STAGES-1, go to GAP. If GAP_CYCLES=0, release stage k+1 on this same edge instead.
  - If it is high and k=N_STAGES-1, go to DONE and set `sys_ready_o` to 1 on that edge.
- **GAP:** counts GAP_CYCLES edges. On the final edge, k increments, `stage_rst_n_o[k]` is set to 1, and state becomes RELEASE.
- **Released stages stay released** until ASSERT is re-entered. Released outputs form a thermometer code: bit i=1 implies every bit below i is 1.
- **Ignored ready inputs:** `stage_rdy_i` bits of unreleased stages are ignored. A drop on a ready bit that was already acknowledged is also ignored.
- **DONE:** hold all outputs until a request or reset.

## Timing

- Edges are numbered from the first rising edge with `rst_n_i`=1 and `init_rst_n_i`=1.
- With all ready inputs tied high:
  - stage k is released at edge HOLD_CYCLES + k·(1+GAP_CYCLES);
  - `sys_ready_o` rises one edge after the last release.
- Defaults (HOLD=16, GAP=4, N=4): stage releases at edges 16, 21, 26 and 31; `sys_ready_o` at edge 32.
- Minimum release-to-next-release spacing is 1+GAP_CYCLES edges.
- **Simultaneous events:**
  - A request arriving on the same edge as a ready acknowledge wins; the state goes to ASSERT.
  - `rst_n_i` assertion overrides everything asynchronously.
- **Mid-sequence request:** all released stages re-enter reset on the next edge, and the full HOLD_CYCLES count restarts.

## Configuration

- Macro: `A_RST_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A wait counter runs in RELEASE and clears on entry to each RELEASE.
  - If `stage_rdy_i[k]` is still low when the counter reaches TIMEOUT_CYCLES, the state goes to FAULT.
  - On that edge, `fault_o` is set to 1, `fault_stage_o` is set to k, and all `stage_rst_n_o` are set to 0.
  - FAULT is exited only by a request or `rst_n_i`. A request clears `fault_o`.
- **Undefined:** RELEASE waits indefinitely. `fault_o` and `fault_stage_o` are tied to 0. The FAULT state and wait counter are not built.

## Test plan

- **Nominal sequence:** defaults, all ready tied high, release reset → releases at edges 16/21/26/31, `sys_ready_o`=1 at edge 32, thermometer code holds throughout.
- **Ready stall:** `stage_rdy_i[2]` raised 40 cycles after stage 2's release → stage 3 released exactly 1+GAP_CYCLES edges after the ready edge, no earlier.
- **Mid-sequence request:** `init_rst_n_i` pulsed low for 1 cycle while stage 1 waits for ready → next edge has `stage_rst_n_o`=0000; stage 0 re-releases 16 edges after the request goes high again.
- **Async reset:** `rst_n_i` asserted between clock edges in DONE → all outputs 0 immediately, with no clock edge needed.
- **GAP_CYCLES=0:** N=4, ready tied high → releases at edges 16/17/18/19, `sys_ready_o` at edge 20.
- **Timeout (macro defined):** TIMEOUT_CYCLES=8, `stage_rdy_i[1]` held low → `fault_o`=1 and `fault_stage_o`=1 eight edges after stage 1's release, all resets 0; a request clears `fault_o`.

Source files
------------

// File: rtl/a_rst_seq.sv
// Staged reset sequencer: releases per-stage active-low resets in index order, each gated on the previous stage's ready.
// Optional ready-wait timeout with FAULT state is built when A_RST_SEQ_TIMEOUT_EN is defined.
module a_rst_seq #(
  parameter int N_STAGES       = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  localparam int IDX_W         = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk_ref,
  input  logic                rst_n_i,
  input  logic                init_rst_n_i,
  input  logic [N_STAGES-1:0] stage_rdy_i,
  output logic [N_STAGES-1:0] stage_rst_n_o,
  output logic                sys_ready_o,
  output logic                fault_o,
  output logic [IDX_W-1:0]    fault_stage_o
);

`ifdef A_RST_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {ST_ASSERT, ST_RELEASE, ST_GAP, ST_DONE, ST_FAULT} state_t;
`else
  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_GAP, ST_DONE} state_t;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     k;
  logic [IDX_W-1:0]     next_k;
  logic [N_STAGES-1:0]  stage_rst_n;
  logic [N_STAGES-1:0]  next_thermo;
  logic                 sys_ready;
  logic                 rdy_k;

  assign next_k = k + IDX_W'(1);
  assign rdy_k  = stage_rdy_i[k];

  // Release mask always rebuilt as a thermometer up to the newly released stage.
  generate
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_thermo
      assign next_thermo[gi] = (IDX_W'(gi) <= next_k);
    end
  endgenerate

`ifdef A_RST_SEQ_TIMEOUT_EN
  logic             fault;
  logic [IDX_W-1:0] fault_stage;
`endif

  // cnt is shared: hold count in ASSERT, gap count in GAP, ready-wait count in RELEASE.
  always_ff @(posedge clk_ref or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      k           <= '0;
      stage_rst_n <= '0;
      sys_ready   <= 1'b0;
`ifdef A_RST_SEQ_TIMEOUT_EN
      fault       <= 1'b0;
      fault_stage <= '0;
`endif
    end else if (!init_rst_n_i) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      k           <= '0;
      stage_rst_n <= '0;
      sys_ready   <= 1'b0;
`ifdef A_RST_SEQ_TIMEOUT_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt            <= '0;
            k              <= '0;
            stage_rst_n[0] <= 1'b1;
            state          <= ST_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (rdy_k) begin
            cnt <= '0;
            if (k == LAST_IDX) begin
              state     <= ST_DONE;
              sys_ready <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              k           <= next_k;
              stage_rst_n <= next_thermo;
            end else begin
              state <= ST_GAP;
            end
          end
`ifdef A_RST_SEQ_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= ST_FAULT;
            fault       <= 1'b1;
            fault_stage <= k;
            stage_rst_n <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            cnt         <= '0;
            k           <= next_k;
            stage_rst_n <= next_thermo;
            state       <= ST_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
        end
`ifdef A_RST_SEQ_TIMEOUT_EN
        ST_FAULT: begin
        end
`endif
        default: state <= ST_ASSERT;
      endcase
    end
  end

  assign stage_rst_n_o = stage_rst_n;
  assign sys_ready_o   = sys_ready;

`ifdef A_RST_SEQ_TIMEOUT_EN
  assign fault_o       = fault;
  assign fault_stage_o = fault_stage;
`else
  assign fault_o       = 1'b0;
  assign fault_stage_o = '0;
`endif

endmodule
